led7seg_74hc595_monitor: RTL

Receive-side counterpart of the 74HC595 LED 7-segment controller. The block deserializes the three-wire stream (`sclk`, `rclk`, `dio`) exactly as the two cascaded 74HC595 chips would, and presents each latched 16-bit word on a parallel valid-strobed output. It maintains an 8-digit segment frame buffer and flags malformed frames. It sits on the bench and on the debug path (board loopback), observing the controller's output pins, and runs in the same 125 MHz `clk` domain as the controller.

---
 rtl/led7seg_74hc595_monitor_if.sv | 26 ++
 rtl/led7seg_74hc595_monitor.sv | 108 ++++++++++
 2 files changed

// File: rtl/led7seg_74hc595_monitor_if.sv
// Pin and readback bundle for the 74HC595 stream monitor.
// The master drives the three pins and the read address; the slave (monitor) answers.
interface led7seg_74hc595_monitor_if #(parameter int NUM_DIG = 8);
  localparam int IW = $clog2(NUM_DIG);

  logic               sclk_i;
  logic               rclk_i;
  logic               dio_i;
  logic [7+NUM_DIG:0] dat;
  logic               vld;
  logic               frm_err;
  logic               sel_err;
  logic [15:0]        latch_cnt;
  logic [IW-1:0]      rd_idx;
  logic [7:0]         rd_seg;

  modport master (
    output sclk_i, rclk_i, dio_i, rd_idx,
    input  dat, vld, frm_err, sel_err, latch_cnt, rd_seg
  );

  modport slave (
    input  sclk_i, rclk_i, dio_i, rd_idx,
    output dat, vld, frm_err, sel_err, latch_cnt, rd_seg
  );
endinterface

// File: rtl/led7seg_74hc595_monitor.sv
// Receive-side model of two cascaded 74HC595s: deserializes sclk/rclk/dio,
// reports each latched word, keeps a per-digit segment buffer and flags bad frames.
module led7seg_74hc595_monitor #(
  parameter int NUM_DIG  = 8,
  parameter int FRM_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  led7seg_74hc595_monitor_if.slave      bus
);
  localparam int          W     = 8 + NUM_DIG;
  localparam int          IW    = $clog2(NUM_DIG);
  localparam int          CW    = $clog2(NUM_DIG + 1);
  localparam logic [4:0]  FRM_N = 5'(FRM_BITS);

  // Chains reset to ones so a pin held high across reset release gives no edge.
  logic [2:0] r_sclk_sy;
  logic [2:0] r_rclk_sy;
  logic [2:0] r_dio_sy;
  logic       r_sclk_p;
  logic       r_rclk_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sy <= '1;
      r_rclk_sy <= '1;
      r_dio_sy  <= '1;
      r_sclk_p  <= 1'b0;
      r_rclk_p  <= 1'b0;
    end else begin
      r_sclk_sy <= {r_sclk_sy[1:0], bus.sclk_i};
      r_rclk_sy <= {r_rclk_sy[1:0], bus.rclk_i};
      r_dio_sy  <= {r_dio_sy[1:0],  bus.dio_i};
      r_sclk_p  <= r_sclk_sy[1] & ~r_sclk_sy[2];
      r_rclk_p  <= r_rclk_sy[1] & ~r_rclk_sy[2];
    end
  end

  // dio is taken from the third stage so it is sampled on the same clk edge
  // that first saw the sclk rise, keeping the hold window short.
  logic w_dio_s;
  assign w_dio_s = r_dio_sy[2];

  logic [W-1:0]          r_shreg;
  logic [4:0]            r_bit_cnt;
  logic [W-1:0]          r_dat;
  logic                  r_vld;
  logic                  r_frm_err;
  logic                  r_sel_err;
  logic [15:0]           r_latch_cnt;
  logic [NUM_DIG-1:0][7:0] r_fb;

  logic [CW-1:0] w_ones;
  logic          w_onehot;
  logic [IW-1:0] w_wr_idx;

  always_comb begin
    w_ones   = '0;
    w_wr_idx = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      w_ones = w_ones + {{(CW-1){1'b0}}, r_shreg[i]};
      if (r_dat[i]) w_wr_idx = IW'(i);
    end
    w_onehot = (w_ones == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_dat       <= '0;
      r_vld       <= 1'b0;
      r_frm_err   <= 1'b0;
      r_sel_err   <= 1'b0;
      r_latch_cnt <= '0;
    end else begin
      r_vld <= 1'b0;
      if (r_sclk_p) r_shreg <= {r_shreg[W-2:0], w_dio_s};
      // A coincident shift lands after the latch, as with tied 595 clocks.
      if (r_rclk_p) begin
        r_dat       <= r_shreg;
        r_frm_err   <= (r_bit_cnt != FRM_N);
        r_sel_err   <= ~w_onehot;
        r_vld       <= 1'b1;
        r_latch_cnt <= r_latch_cnt + 16'd1;
        r_bit_cnt   <= r_sclk_p ? 5'd1 : 5'd0;
      end else if (r_sclk_p && r_bit_cnt != 5'd31) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  // Buffer is written from the latched word while vld is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fb <= '0;
    end else if (r_vld && !r_frm_err && !r_sel_err) begin
      r_fb[w_wr_idx] <= r_dat[W-1:NUM_DIG];
    end
  end

  assign bus.dat       = r_dat;
  assign bus.vld       = r_vld;
  assign bus.frm_err   = r_frm_err;
  assign bus.sel_err   = r_sel_err;
  assign bus.latch_cnt = r_latch_cnt;
  assign bus.rd_seg    = r_fb[bus.rd_idx];
endmodule
